mult_accum_stage: RTL and testbench

MULT_ACCUM_STAGE -- requirements
Module: mult_accum_stage

---
 rtl/mult_accum_stage.sv | 71 +++++++
 tb/tb_mult_accum_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_accum_stage.sv
// mult_accum_stage: sums len signed 32-bit products into an ACC_W-bit accumulator.
// Define MAC_SAT_EN for saturating adds with a sticky sat flag; otherwise adds wrap.
module mult_accum_stage #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             sat
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t r_state, w_next;
  logic [ACC_W-1:0] r_acc, w_sum, w_prod;
  logic [CNT_W-1:0] r_rem;
  logic r_sat, w_ovf, w_xfer, w_load;
  assign w_prod = {{(ACC_W-32){product[31]}}, product};
`ifdef MAC_SAT_EN
  logic [ACC_W:0] w_wide;
  assign w_wide = {w_prod[ACC_W-1], w_prod} + {r_acc[ACC_W-1], r_acc};
  assign w_ovf = w_wide[ACC_W] ^ w_wide[ACC_W-1];
  // on overflow the true sign bit picks min or max
  assign w_sum = w_ovf ? {w_wide[ACC_W], {(ACC_W-1){~w_wide[ACC_W]}}} : w_wide[ACC_W-1:0];
`else
  assign w_ovf = 1'b0;
  assign w_sum = r_acc + w_prod;
`endif
  assign w_xfer = in_valid && r_state == ACC;
  assign w_load = start && r_state == IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (len != '0 ? ACC : DONE) : IDLE;
      ACC:     w_next = (w_xfer && r_rem == CNT_W'(1)) ? DONE : ACC;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_acc <= '0;
        r_rem <= len;
        r_sat <= 1'b0;
      end else if (w_xfer) begin
        r_acc <= w_sum;
        r_rem <= r_rem - CNT_W'(1);
        r_sat <= r_sat | w_ovf;
      end
    end
  end
  assign in_ready  = r_state == ACC;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign acc_out   = r_acc;
  assign sat       = r_sat;
endmodule

// File: tb/tb_mult_accum_stage.sv
// tb_mult_accum_stage: drives a 40-bit and a 33-bit instance in lockstep against a transaction model.
module tb_mult_accum_stage;
`ifdef MAC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
  logic [7:0] len = 0;
  logic [31:0] product = 0;
  logic ir40, ov40, busy40, sat40, ir33, ov33, busy33, sat33;
  logic [39:0] acc40;
  logic [32:0] acc33;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  mult_accum_stage #(.ACC_W(40), .CNT_W(8)) u40 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir40),
    .product(product), .out_valid(ov40), .out_ready(out_ready), .acc_out(acc40),
    .busy(busy40), .sat(sat40));
  mult_accum_stage #(.ACC_W(33), .CNT_W(8)) u33 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(ir33),
    .product(product), .out_valid(ov33), .out_ready(out_ready), .acc_out(acc33),
    .busy(busy33), .sat(sat33));
  task automatic chk(string nm, longint act, longint exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic longint add_w(longint a, longint p, int w);
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint s = a + p;
    longint t = s & ((longint'(1) << w) - 1);
    if (SAT_EN) return s > mx ? mx : (s < -mx - 1 ? -mx - 1 : s);
    return t > mx ? t - (longint'(1) << w) : t;
  endfunction
  longint w_p;
  assign w_p = longint'($signed(product));
  longint m_a40 = 0, m_a33 = 0;
  bit m_s40 = 0, m_s33 = 0, m_acc = 0, m_done = 0;
  int m_left = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_acc <= 0; m_done <= 0; m_left <= 0;
      m_a40 <= 0; m_a33 <= 0; m_s40 <= 0; m_s33 <= 0;
    end else if (m_done) begin
      if (out_ready) m_done <= 0;
    end else if (m_acc) begin
      if (in_valid) begin
        m_a40 <= add_w(m_a40, w_p, 40);
        m_a33 <= add_w(m_a33, w_p, 33);
        m_s40 <= m_s40 | (SAT_EN && add_w(m_a40, w_p, 40) != m_a40 + w_p);
        m_s33 <= m_s33 | (SAT_EN && add_w(m_a33, w_p, 33) != m_a33 + w_p);
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_acc <= 0;
          m_done <= 1;
        end
      end
    end else if (start) begin
      m_a40 <= 0; m_a33 <= 0; m_s40 <= 0; m_s33 <= 0;
      m_left <= int'(len);
      m_acc <= len != 0;
      m_done <= len == 0;
    end
  end
  always @(negedge clk) begin
    chk("in_ready40", longint'(ir40), longint'(m_acc));
    chk("in_ready33", longint'(ir33), longint'(m_acc));
    chk("out_valid40", longint'(ov40), longint'(m_done));
    chk("out_valid33", longint'(ov33), longint'(m_done));
    chk("busy40", longint'(busy40), longint'(m_acc | m_done));
    chk("busy33", longint'(busy33), longint'(m_acc | m_done));
    chk("sat40", longint'(sat40), longint'(m_s40));
    chk("sat33", longint'(sat33), longint'(m_s33));
    chk("acc40", longint'($signed(acc40)), m_a40);
    chk("acc33", longint'($signed(acc33)), m_a33);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ov();
    int k = 0;
    while (!ov40 && k < 40) begin
      step();
      k++;
    end
    chk("out_valid_timeout", longint'(ov40), 1);
  endtask
  task automatic run_n(int n, logic [31:0] p);
    start = 1; len = 8'(n);
    step();
    start = 0; in_valid = 1; product = p;
    repeat (n) step();
    in_valid = 0;
    wait_ov();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_in_ready", longint'(ir40), 0);
    chk("rst_out_valid", longint'(ov40), 0);
    chk("rst_busy", longint'(busy40), 0);
    chk("rst_acc", longint'($signed(acc40)), 0);
    step();
    start = 1; len = 3;
    step();
    start = 0; in_valid = 1; product = 32'h00000006;
    step();
    product = 32'hFFFFFFFE;
    step();
    product = 32'h0000000A;
    step();
    in_valid = 0;
    wait_ov();
    chk("sum3_acc40", longint'($signed(acc40)), 14);
    chk("sum3_acc33", longint'($signed(acc33)), 14);
    start = 1; len = 2;
    step();
    start = 0;
    chk("start_at_handshake_busy", longint'(busy40), 0);
    chk("start_at_handshake_ov", longint'(ov40), 0);
    start = 1; len = 0;
    step();
    start = 0;
    chk("len0_ov", longint'(ov40), 1);
    chk("len0_acc", longint'($signed(acc40)), 0);
    chk("len0_in_ready", longint'(ir40), 0);
    step();
    chk("len0_idle", longint'(busy40), 0);
    out_ready = 0;
    start = 1; len = 2;
    step();
    start = 0; in_valid = 1; product = 32'hFFFFFF9C;
    step();
    in_valid = 0; start = 1; len = 5;
    step();
    start = 0;
    repeat (4) step();
    in_valid = 1; product = 32'd250;
    step();
    in_valid = 0;
    chk("stall_ov", longint'(ov40), 1);
    chk("stall_acc", longint'($signed(acc40)), 150);
    repeat (3) begin
      step();
      chk("hold_acc", longint'($signed(acc40)), 150);
      chk("hold_ov", longint'(ov40), 1);
    end
    out_ready = 1;
    step();
    chk("release_ov", longint'(ov40), 0);
    run_n(5, 32'h3FFFFFFF);
    chk("pos_acc33", longint'($signed(acc33)), SAT_EN ? 64'sd4294967295 : -64'sd3221225477);
    chk("pos_sat33", longint'(sat33), longint'(SAT_EN));
    chk("pos_acc40", longint'($signed(acc40)), 64'sd5368709115);
    chk("pos_sat40", longint'(sat40), 0);
    step();
    run_n(3, 32'h80000000);
    chk("neg_acc33", longint'($signed(acc33)), SAT_EN ? -64'sd4294967296 : 64'sd2147483648);
    chk("neg_sat33", longint'(sat33), longint'(SAT_EN));
    chk("neg_acc40", longint'($signed(acc40)), -64'sd6442450944);
    step();
    start = 1; len = 5;
    step();
    start = 0; in_valid = 1; product = 32'd1;
    step();
    product = 32'd2;
    step();
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    chk("midrst_busy", longint'(busy40), 0);
    chk("midrst_acc", longint'($signed(acc40)), 0);
    chk("midrst_ov", longint'(ov40), 0);
    run_n(1, 32'h00000007);
    chk("after_rst_acc40", longint'($signed(acc40)), 7);
    chk("after_rst_acc33", longint'($signed(acc33)), 7);
    chk("after_rst_sat33", longint'(sat33), 0);
    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
